// File: rtl/cordic_pkg.sv
// Shared constants and helpers for the pipelined CORDIC engine: arctangent table,
// inverse-gain constant, mode encodings and a generic saturation function.
package cordic_pkg;

  localparam logic MODE_ROT  = 1'b0;
  localparam logic MODE_VEC  = 1'b1;
  localparam int   INV_K_Q15 = 19898;

  // atan(2^-i) as a fraction of a full turn, scaled by 2^32
  function automatic logic [31:0] atan_entry(input int idx);
    case (idx)
      0:       return 32'h2000_0000;
      1:       return 32'h12E4_051D;
      2:       return 32'h09FB_385B;
      3:       return 32'h0511_11D4;
      4:       return 32'h028B_0D43;
      5:       return 32'h0145_D7E1;
      6:       return 32'h00A2_F61E;
      7:       return 32'h0051_7C55;
      8:       return 32'h0028_BE53;
      9:       return 32'h0014_5F2E;
      10:      return 32'h000A_2F98;
      11:      return 32'h0005_17CC;
      12:      return 32'h0002_8BE6;
      13:      return 32'h0001_45F3;
      14:      return 32'h0000_A2F9;
      15:      return 32'h0000_517C;
      default: return 32'h0000_0000;
    endcase
  endfunction

  // Clamp a wide signed value into the range of a w-bit two's complement number
  function automatic logic signed [47:0] sat_width(input logic signed [47:0] v, input int w);
    logic signed [47:0] hi;
    logic signed [47:0] lo;
    hi = (48'sd1 <<< (w - 1)) - 48'sd1;
    lo = -(48'sd1 <<< (w - 1));
    if (v > hi)      return hi;
    else if (v < lo) return lo;
    else             return v;
  endfunction

endpackage

// File: rtl/cordic_stage.sv
// One registered CORDIC micro-rotation with a shared pipeline enable; the shift
// amount selects both the operand shift and the arctangent constant.
module cordic_stage
  import cordic_pkg::*;
#(
  parameter int DW      = 18,
  parameter int ANGLE_W = 16,
  parameter int SHIFT   = 0
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      en,
  input  logic                      mode,
  input  logic signed [DW-1:0]      x_in,
  input  logic signed [DW-1:0]      y_in,
  input  logic        [ANGLE_W-1:0] z_in,
  output logic signed [DW-1:0]      x_out,
  output logic signed [DW-1:0]      y_out,
  output logic        [ANGLE_W-1:0] z_out
);

  localparam logic [31:0]        ATAN_FULL = atan_entry(SHIFT);
  localparam logic [ANGLE_W-1:0] ATAN      = ANGLE_W'(ATAN_FULL >> (32 - ANGLE_W));

  logic signed [DW-1:0] x_sh;
  logic signed [DW-1:0] y_sh;
  logic                 d_pos;

  assign x_sh  = x_in >>> SHIFT;
  assign y_sh  = y_in >>> SHIFT;
  assign d_pos = (mode == MODE_ROT) ? ~z_in[ANGLE_W-1] : y_in[DW-1];

  // NOTE: datapath registers are reset too, so outputs read as zero immediately after reset.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      x_out <= '0;
      y_out <= '0;
      z_out <= '0;
    end else if (en) begin
      if (d_pos) begin
        x_out <= x_in - y_sh;
        y_out <= y_in + x_sh;
        z_out <= z_in - ATAN;
      end else begin
        x_out <= x_in + y_sh;
        y_out <= y_in - x_sh;
        z_out <= z_in + ATAN;
      end
    end
  end

endmodule

// File: rtl/cordic_pipe_engine.sv
// Fully pipelined rotation/vectoring CORDIC with quadrant pre-rotation and valid/ready
// flow control. Define CORDIC_GAIN_COMP_EN to add a 1/K gain-compensation output stage.
module cordic_pipe_engine
  import cordic_pkg::*;
#(
  parameter int WIDTH   = 16,
  parameter int ANGLE_W = 16,
  parameter int STAGES  = 14,
  parameter int GUARD   = 2
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic                      in_mode,
  input  logic signed [WIDTH-1:0]   in_x,
  input  logic signed [WIDTH-1:0]   in_y,
  input  logic        [ANGLE_W-1:0] in_z,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic                      out_mode,
  output logic signed [WIDTH-1:0]   out_x,
  output logic signed [WIDTH-1:0]   out_y,
  output logic        [ANGLE_W-1:0] out_z
);

  localparam int DW = WIDTH + GUARD;

  logic stall;
  logic en;

  // The whole pipe freezes while the head result is refused; bubbles are never squeezed out.
  assign stall    = out_valid & ~out_ready;
  assign en       = ~stall;
  assign in_ready = ~stall;

  logic signed [DW-1:0]      ext_x;
  logic signed [DW-1:0]      ext_y;
  logic signed [DW-1:0]      pre_x;
  logic signed [DW-1:0]      pre_y;
  logic        [ANGLE_W-1:0] pre_z;
  logic                      flip;

  // NOTE: every always_comb output is assigned on every path, so no latch is inferred.
  always_comb begin
    ext_x = DW'(in_x);
    ext_y = DW'(in_y);
    flip  = (in_mode == MODE_ROT) ? (in_z[ANGLE_W-1] ^ in_z[ANGLE_W-2]) : ext_x[DW-1];
    pre_x = flip ? -ext_x : ext_x;
    pre_y = flip ? -ext_y : ext_y;
    pre_z = flip ? {~in_z[ANGLE_W-1], in_z[ANGLE_W-2:0]} : in_z;
  end

  logic signed [DW-1:0]      p_x;
  logic signed [DW-1:0]      p_y;
  logic        [ANGLE_W-1:0] p_z;
  logic        [STAGES:0]    v_pipe;
  logic        [STAGES:0]    m_pipe;

  // Bit 0 of the valid/mode chains tracks stage P, bit k+1 tracks micro-rotation k.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      p_x    <= '0;
      p_y    <= '0;
      p_z    <= '0;
      v_pipe <= '0;
      m_pipe <= '0;
    end else if (en) begin
      p_x    <= pre_x;
      p_y    <= pre_y;
      p_z    <= pre_z;
      v_pipe <= {v_pipe[STAGES-1:0], in_valid};
      m_pipe <= {m_pipe[STAGES-1:0], in_mode};
    end
  end

  logic signed [DW-1:0]      st_x [STAGES];
  logic signed [DW-1:0]      st_y [STAGES];
  logic        [ANGLE_W-1:0] st_z [STAGES];

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    logic signed [DW-1:0]      xi;
    logic signed [DW-1:0]      yi;
    logic        [ANGLE_W-1:0] zi;

    if (k == 0) begin : g_first
      assign xi = p_x;
      assign yi = p_y;
      assign zi = p_z;
    end else begin : g_next
      assign xi = st_x[k-1];
      assign yi = st_y[k-1];
      assign zi = st_z[k-1];
    end

    cordic_stage #(
      .DW      (DW),
      .ANGLE_W (ANGLE_W),
      .SHIFT   (k)
    ) u_stage (
      .clk   (clk),
      .reset (reset),
      .en    (en),
      .mode  (m_pipe[k]),
      .x_in  (xi),
      .y_in  (yi),
      .z_in  (zi),
      .x_out (st_x[k]),
      .y_out (st_y[k]),
      .z_out (st_z[k])
    );
  end

`ifdef CORDIC_GAIN_COMP_EN
  logic signed [47:0]        prod_x;
  logic signed [47:0]        prod_y;
  logic signed [WIDTH-1:0]   g_x;
  logic signed [WIDTH-1:0]   g_y;
  logic        [ANGLE_W-1:0] g_z;
  logic                      g_valid;
  logic                      g_mode;

  assign prod_x = (48'(st_x[STAGES-1]) * 48'(INV_K_Q15)) >>> 15;
  assign prod_y = (48'(st_y[STAGES-1]) * 48'(INV_K_Q15)) >>> 15;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      g_x     <= '0;
      g_y     <= '0;
      g_z     <= '0;
      g_valid <= 1'b0;
      g_mode  <= 1'b0;
    end else if (en) begin
      g_x     <= WIDTH'(sat_width(prod_x, WIDTH));
      g_y     <= WIDTH'(sat_width(prod_y, WIDTH));
      g_z     <= st_z[STAGES-1];
      g_valid <= v_pipe[STAGES];
      g_mode  <= m_pipe[STAGES];
    end
  end

  assign out_x     = g_x;
  assign out_y     = g_y;
  assign out_z     = g_z;
  assign out_valid = g_valid;
  assign out_mode  = g_mode;
`else
  assign out_x     = WIDTH'(sat_width(48'(st_x[STAGES-1]), WIDTH));
  assign out_y     = WIDTH'(sat_width(48'(st_y[STAGES-1]), WIDTH));
  assign out_z     = st_z[STAGES-1];
  assign out_valid = v_pipe[STAGES];
  assign out_mode  = m_pipe[STAGES];
`endif

endmodule

// File: tb/tb_cordic_pipe_engine.sv
// Self-checking bench for cordic_pipe_engine: directed vectors, a randomized stream with
// backpressure, random handshakes and reset mid-flight, all scored against an ideal trig model.
module tb_cordic_pipe_engine;

  localparam int  WIDTH   = 16;
  localparam int  ANGLE_W = 16;
  localparam int  STAGES  = 14;
  localparam int  GUARD   = 2;
  localparam real PI      = 3.14159265358979;
`ifdef CORDIC_GAIN_COMP_EN
  localparam int  LAT     = STAGES + 2;
`else
  localparam int  LAT     = STAGES + 1;
`endif

  logic                      clk;
  logic                      reset;
  logic                      in_valid;
  logic                      in_ready;
  logic                      in_mode;
  logic signed [WIDTH-1:0]   in_x;
  logic signed [WIDTH-1:0]   in_y;
  logic        [ANGLE_W-1:0] in_z;
  logic                      out_valid;
  logic                      out_ready;
  logic                      out_mode;
  logic signed [WIDTH-1:0]   out_x;
  logic signed [WIDTH-1:0]   out_y;
  logic        [ANGLE_W-1:0] out_z;

  cordic_pipe_engine #(
    .WIDTH   (WIDTH),
    .ANGLE_W (ANGLE_W),
    .STAGES  (STAGES),
    .GUARD   (GUARD)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_mode   (in_mode),
    .in_x      (in_x),
    .in_y      (in_y),
    .in_z      (in_z),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_mode  (out_mode),
    .out_x     (out_x),
    .out_y     (out_y),
    .out_z     (out_z)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    bit  mode;
    real x;
    real y;
    real z;
    real tol_xy;
    real tol_z;
    int  acc_cyc;
    bit  chk_lat;
  } exp_t;

  typedef struct {
    bit mode;
    int x;
    int y;
    int z;
  } vec_t;

  exp_t sb[$];
  int   n_vec = 0;
  int   n_err = 0;
  bit   cur_lat = 1'b0;
  real  cur_tol_xy = 6.0;
  real  cur_tol_z  = 6.0;

  // Ideal result: exact trig scaled by the CORDIC gain (times 1/K when compensated).
  function automatic exp_t model(input bit mode, input int x, input int y, input int z);
    exp_t e;
    real  g;
    real  p;
    real  th;
    real  lim_hi;
    real  lim_lo;
    g = 1.0;
    p = 1.0;
    for (int i = 0; i < STAGES; i++) begin
      g = g * $sqrt(1.0 + p);
      p = p * 0.25;
    end
`ifdef CORDIC_GAIN_COMP_EN
    g = g * 19898.0 / 32768.0;
`endif
    e.mode = mode;
    if (!mode) begin
      th  = real'(z) * PI / 32768.0;
      e.x = g * (real'(x) * $cos(th) - real'(y) * $sin(th));
      e.y = g * (real'(x) * $sin(th) + real'(y) * $cos(th));
      e.z = 0.0;
    end else begin
      e.x = g * $sqrt(real'(x) * real'(x) + real'(y) * real'(y));
      e.y = 0.0;
      e.z = real'(z) + $atan2(real'(y), real'(x)) * 32768.0 / PI;
    end
    lim_hi = 32767.0;
    lim_lo = -32768.0;
    if (e.x > lim_hi) e.x = lim_hi;
    if (e.x < lim_lo) e.x = lim_lo;
    if (e.y > lim_hi) e.y = lim_hi;
    if (e.y < lim_lo) e.y = lim_lo;
    e.tol_xy  = 0.0;
    e.tol_z   = 0.0;
    e.acc_cyc = 0;
    e.chk_lat = 1'b0;
    return e;
  endfunction

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    assert (got === exp)
    else begin
      n_err++;
      $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic check_tol(input string tag, input real got, input real exp, input real tol);
    bit ok;
    ok = (got - exp <= tol) && (exp - got <= tol);
    assert (ok === 1'b1)
    else begin
      n_err++;
      $error("FAIL %s: observed %0.1f expected %0.1f (+-%0.1f)", tag, got, exp, tol);
    end
  endtask

  // Angles wrap, so the difference is folded into [-32768, 32768) before the tolerance test.
  task automatic check_z(input string tag, input logic [ANGLE_W-1:0] got, input real exp, input real tol);
    real g;
    real d;
    g = real'($signed(got));
    d = g - exp;
    d = d - 65536.0 * $floor(d / 65536.0 + 0.5);
    check_tol(tag, g, g - d, tol);
  endtask

  // One clock: sample the handshakes at the falling edge, score them, return just after the rising edge.
  task automatic tick(output bit acc, output bit rdy);
    exp_t e;
    @(negedge clk);
    acc = in_valid && in_ready;
    rdy = in_ready;
    if (acc) begin
      e         = model(in_mode, int'(in_x), int'(in_y), int'($signed(in_z)));
      e.acc_cyc = cyc;
      e.chk_lat = cur_lat;
      e.tol_xy  = cur_tol_xy;
      e.tol_z   = cur_tol_z;
      sb.push_back(e);
      n_vec++;
    end
    if (out_valid && out_ready) begin
      if (sb.size() == 0) begin
        check("spurious_out", 64'(out_valid), 64'd0);
      end else begin
        e = sb.pop_front();
        check_tol("out_x", real'(out_x), e.x, e.tol_xy);
        check_tol("out_y", real'(out_y), e.y, e.tol_xy);
        check_z("out_z", out_z, e.z, e.tol_z);
        check("out_mode", 64'(out_mode), 64'(e.mode));
        if (e.chk_lat) check("latency", 64'(cyc - e.acc_cyc), 64'(LAT));
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input bit mode, input int x, input int y, input int z);
    in_mode = mode;
    in_x    = WIDTH'(x);
    in_y    = WIDTH'(y);
    in_z    = ANGLE_W'(z);
  endtask

  task automatic drive_rand();
    int x;
    int y;
    int z;
    x = int'($urandom_range(4000, 12000));
    if ($urandom_range(0, 1) == 1) x = -x;
    y = int'($urandom_range(0, 24000)) - 12000;
    z = int'($urandom_range(0, 65535)) - 32768;
    drive(1'($urandom_range(0, 1)), x, y, z);
  endtask

  task automatic drain();
    bit a;
    bit r;
    int n;
    n         = 0;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    while (sb.size() != 0 && n < 100) begin
      tick(a, r);
      n++;
    end
    check("drain_empty", 64'(sb.size()), 64'd0);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t dir_vec [7];
    bit   acc;
    bit   rdy;
    int   sc;
    int   n_acc;
    int   n;
    int   seen;

    dir_vec = '{
      '{1'b0,  16384,      0,  16384},
      '{1'b1,  10000,  10000,      0},
      '{1'b0,  16384,      0,  32767},
      '{1'b1, -10000,      0,      0},
      '{1'b0,  30000,      0,      0},
      '{1'b0,  16384,      0, -16384},
      '{1'b1,      0, -12000,      0}
    };

    reset     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    drive(1'b0, 0, 0, 0);
    repeat (2) @(negedge clk);
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_out_x", 64'(out_x), 64'd0);
    check("rst_out_y", 64'(out_y), 64'd0);
    check("rst_out_z", 64'(out_z), 64'd0);
    check("rst_in_ready", 64'(in_ready), 64'd1);
    reset = 1'b1;
    @(posedge clk);
    #1;

    // Directed vectors, one at a time, with latency checked on each.
    cur_lat    = 1'b1;
    cur_tol_xy = 6.0;
    cur_tol_z  = 6.0;
    for (int i = 0; i < 7; i++) begin
      drive(dir_vec[i].mode, dir_vec[i].x, dir_vec[i].y, dir_vec[i].z);
      in_valid = 1'b1;
      tick(acc, rdy);
      check("dir_accept", 64'(acc), 64'd1);
      drain();
    end

    // Continuous random stream with a 5-cycle consumer stall in the middle.
    cur_lat    = 1'b0;
    cur_tol_xy = 48.0;
    cur_tol_z  = 32.0;
    sc         = 0;
    n_acc      = 0;
    acc        = 1'b1;
    while (n_acc < 200 && sc < 400) begin
      if (acc) drive_rand();
      in_valid  = 1'b1;
      out_ready = !(sc >= 60 && sc < 65);
      tick(acc, rdy);
      if (sc >= 60 && sc < 65) check("bp_in_ready", 64'(rdy), 64'd0);
      else                     check("tput_in_ready", 64'(rdy), 64'd1);
      if (acc) n_acc++;
      sc++;
    end
    check("stream_cycles", 64'(sc), 64'd205);
    drain();

    // Random valid/ready on both sides.
    for (int i = 0; i < 300; i++) begin
      drive_rand();
      in_valid  = ($urandom_range(0, 9) < 7);
      out_ready = ($urandom_range(0, 9) < 7);
      tick(acc, rdy);
    end
    drain();

    // Reset with three samples in flight and the head result stalled.
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      drive_rand();
      in_valid = 1'b1;
      tick(acc, rdy);
    end
    in_valid = 1'b0;
    n = 0;
    while (!out_valid && n < LAT + 5) begin
      tick(acc, rdy);
      n++;
    end
    check("stalled_valid", 64'(out_valid), 64'd1);
    @(negedge clk);
    #2;
    reset = 1'b0;
    #1;
    check("midrst_out_valid", 64'(out_valid), 64'd0);
    check("midrst_out_x", 64'(out_x), 64'd0);
    check("midrst_in_ready", 64'(in_ready), 64'd1);
    sb.delete();
    @(negedge clk);
    #2;
    reset = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    seen      = 0;
    for (int i = 0; i < 30; i++) begin
      tick(acc, rdy);
      if (out_valid) seen++;
    end
    check("post_rst_quiet", 64'(seen), 64'd0);

    cur_lat    = 1'b1;
    cur_tol_xy = 6.0;
    cur_tol_z  = 6.0;
    drive(1'b1, 10000, 10000, 0);
    in_valid = 1'b1;
    tick(acc, rdy);
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
